// File: rtl/dmux8_1to4b_pkg.sv
// dmux8_pkg -- shared types and constants for the dmux8_1to4b routing stage.
//
// Contents:
//   DMUX8_WIDTH  default lane data width (8)
//   lane_sel_t   2-bit lane select code: LANE_W=0, LANE_X=1, LANE_Y=2, LANE_Z=3
//   lane_data_t  one lane's data word
package dmux8_pkg;

  localparam int DMUX8_WIDTH = 8;

  typedef enum logic [1:0] {
    LANE_W = 2'd0,
    LANE_X = 2'd1,
    LANE_Y = 2'd2,
    LANE_Z = 2'd3
  } lane_sel_t;

  typedef logic [DMUX8_WIDTH-1:0] lane_data_t;

endpackage

// File: rtl/dmux8_1to4b_lane_reg.sv
// dmux8_lane_reg -- one output lane of the 1-to-4 demux: data register plus
// a single-cycle valid strobe.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears data and valid
//   load   in   capture data this edge and raise valid for one cycle
//   clear  in   lane not selected this edge: zero the data register
//   data   in   WIDTH-bit word to capture
//   q      out  registered lane data
//   vld    out  registered valid strobe
//
// Build option:
//   DMUX8_HOLD_EN  when defined, clear is ignored for data: an unloaded lane
//                  keeps its previous word. vld is a one-cycle strobe either way.
module dmux8_lane_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  logic [WIDTH-1:0] q_reg;
  logic             vld_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg   <= '0;
      vld_reg <= 1'b0;
    end else begin
      // Valid only marks the edge the lane was actually written.
      vld_reg <= load;
      if (load) begin
        q_reg <= data;
      end
`ifndef DMUX8_HOLD_EN
      else if (clear) begin
        q_reg <= '0;
      end
`endif
    end
  end

`ifdef DMUX8_HOLD_EN
  // Data holds regardless of clear in this build.
  logic unused_clear;
  assign unused_clear = clear;
`endif

  assign q   = q_reg;
  assign vld = vld_reg;

endmodule

// File: rtl/dmux8_1to4b.sv
// dmux8_1to4b -- registered 1-to-4 demultiplexer for an 8-bit data word.
// Routes A to the lane chosen by Sel one cycle after the sampling edge; the
// other lanes are cleared (or held, see below) and vld is one-hot on the
// loaded lane. No combinational path from inputs to outputs.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears all lanes and vld
//   en     in   transfer enable; A/Sel sampled only when en=1
//   A      in   WIDTH-bit data word
//   Sel    in   lane select: 00=W 01=X 10=Y 11=Z
//   W,X,Y,Z out lane 0..3 data
//   vld    out  per-lane valid, bit0=W .. bit3=Z
//
// Build option:
//   DMUX8_HOLD_EN  unselected / idle lanes hold their data instead of clearing.
module dmux8_1to4b
  import dmux8_pkg::*;
#(
  parameter int WIDTH = DMUX8_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       Sel,
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic [3:0]       vld
);

  lane_sel_t        sel_code;
  logic [3:0]       load_vec;
  logic [WIDTH-1:0] lane_q [4];

  assign sel_code = lane_sel_t'(Sel);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      // Exactly one load strobe when enabled, none when idle.
      assign load_vec[gi] = en && (sel_code == lane_sel_t'(gi));

      dmux8_lane_reg #(
        .WIDTH (WIDTH)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_vec[gi]),
        .clear (~load_vec[gi]),
        .data  (A),
        .q     (lane_q[gi]),
        .vld   (vld[gi])
      );
    end
  endgenerate

  assign W = lane_q[LANE_W];
  assign X = lane_q[LANE_X];
  assign Y = lane_q[LANE_Y];
  assign Z = lane_q[LANE_Z];

`ifndef SYNTHESIS
  // An unknown select during a transfer has no defined routing.
  sel_known_a: assert property (@(posedge clk) disable iff (!rst_n) en |-> !$isunknown(Sel));
`endif

endmodule

// File: tb/tb_dmux8_1to4b.sv
// tb_dmux8_1to4b -- directed self-checking bench for dmux8_1to4b.
// Expected lane contents come from a small reference model; each driven
// transfer pushes its expectation to a queue, popped one cycle later.
// Honours DMUX8_HOLD_EN in the model when the DUT is built with it.
module tb_dmux8_1to4b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] A;
  logic [1:0] Sel;
  logic [7:0] W, X, Y, Z;
  logic [3:0] vld;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] w, x, y, z;
    logic [3:0] v;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_lane [4];

  always #5 clk = ~clk;

  dmux8_1to4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (A),
    .Sel   (Sel),
    .W     (W),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .vld   (vld)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check8({tag, ".W"}, W, e.w);
    check8({tag, ".X"}, X, e.x);
    check8({tag, ".Y"}, Y, e.y);
    check8({tag, ".Z"}, Z, e.z);
    check4({tag, ".vld"}, vld, e.v);
    $display("txn %-10s W=%h X=%h Y=%h Z=%h vld=%b", tag, W, X, Y, Z, vld);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
    sb.delete();
  endtask

  // Drive one cycle of inputs, record the expected result, then compare it
  // just after the capturing edge.
  task automatic step(input string tag, input logic e, input logic [7:0] a, input logic [1:0] s);
    exp_t exp_v;
    @(negedge clk);
    en  = e;
    A   = a;
    Sel = s;
    for (int i = 0; i < 4; i++) begin
      if (e && (int'(s) == i)) m_lane[i] = a;
`ifndef DMUX8_HOLD_EN
      else m_lane[i] = 8'h00;
`endif
    end
    exp_v.w = m_lane[0];
    exp_v.x = m_lane[1];
    exp_v.y = m_lane[2];
    exp_v.z = m_lane[3];
    exp_v.v = e ? (4'b0001 << s) : 4'b0000;
    sb.push_back(exp_v);
    @(posedge clk);
    #1;
    check_all(tag, sb.pop_front());
  endtask

  exp_t zero_e;

  initial begin
    zero_e = '{w: 8'h00, x: 8'h00, y: 8'h00, z: 8'h00, v: 4'b0000};
    rst_n = 1'b0;
    en    = 1'b1;
    A     = 8'hFF;
    Sel   = 2'b00;
    model_reset();
    #2;
    check_all("rst_init", zero_e);
    @(posedge clk);
    #1;
    check_all("rst_hold", zero_e);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep all lanes with all-ones data.
    step("sweep0", 1'b1, 8'hFF, 2'b00);
    step("sweep1", 1'b1, 8'hFF, 2'b01);
    step("sweep2", 1'b1, 8'hFF, 2'b10);
    step("sweep3", 1'b1, 8'hFF, 2'b11);

    // Data integrity on Y, plus inputs changing between edges.
    step("integ_a5", 1'b1, 8'hA5, 2'b10);
    #2;
    A   = 8'hFF;
    Sel = 2'b00;
    #1;
    check8("midcyc.Y", Y, 8'hA5);
    check8("midcyc.W", W, 8'h00);
    step("integ_5a", 1'b1, 8'h5A, 2'b10);

    // Transfer then idle: Z must never be loaded.
    step("idle_ld", 1'b1, 8'h3C, 2'b01);
    step("idle", 1'b0, 8'hFF, 2'b11);

    // Zero data still raises valid.
    step("zero", 1'b1, 8'h00, 2'b01);

    // Two loads to different lanes (hold build keeps W).
    step("hold_w", 1'b1, 8'h11, 2'b00);
    step("hold_x", 1'b1, 8'h22, 2'b01);

    // Asynchronous reset mid-cycle with a live transfer on the inputs.
    en    = 1'b1;
    A     = 8'hFF;
    Sel   = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst", zero_e);
    @(posedge clk);
    #1;
    check_all("rst_low", zero_e);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset.
    step("recover", 1'b1, 8'h77, 2'b11);
    step("idle_end", 1'b0, 8'h00, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
